// File: rtl/com_rx_pkg.sv
// Shared com-link definitions: PID bytes, btype codes, field lengths,
// error codes, receiver state encoding and the byte-wide CRC helpers.
package com_rx_pkg;

  // Link bytes. DATA1 and the preamble share 8'h5A; only the byte's
  // position right after SYNC tells them apart.
  localparam logic [7:0] PID_IDLE  = 8'h00;
  localparam logic [7:0] PID_SYNC  = 8'h0F;
  localparam logic [7:0] PID_PREM  = 8'h5A;
  localparam logic [7:0] PID_ACK   = 8'h2D;
  localparam logic [7:0] PID_NAK   = 8'hA5;
  localparam logic [7:0] PID_STL   = 8'hE1;
  localparam logic [7:0] PID_STAT  = 8'hD2;
  localparam logic [7:0] PID_DATA0 = 8'h96;
  localparam logic [7:0] PID_DATA1 = 8'h5A;

  // Packet type codes reported to the link controller.
  localparam logic [3:0] BAG_NONE  = 4'b0000;
  localparam logic [3:0] BAG_ACK   = 4'b0001;
  localparam logic [3:0] BAG_NAK   = 4'b0010;
  localparam logic [3:0] BAG_STL   = 4'b0011;
  localparam logic [3:0] BAG_STAT  = 4'b1000;
  localparam logic [3:0] BAG_DATA0 = 4'b1101;
  localparam logic [3:0] BAG_DATA1 = 4'b1110;

  // Length field bytes, CRC16 bytes, minimum preamble run.
  localparam int NLEN = 2;
  localparam int CLEN = 2;
  localparam int PLEN = 4;

  localparam logic [11:0] RAM_ADDR_INIT_DEF = 12'hFF0;
  localparam logic [11:0] MAX_DLEN_DEF      = 12'hFFF;

  // Receive status codes.
  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_CRC = 2'b01;
  localparam logic [1:0] ERR_PID = 2'b10;
  localparam logic [1:0] ERR_LEN = 2'b11;

  // CRC polynomials (implicit top term), zero initial value, MSB-first.
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [4:0]  CRC5_POLY  = 5'h05;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_WAIT  = 4'd1,
    S_PREM  = 4'd2,
    S_WPID  = 4'd3,
    S_DNUM  = 4'd4,
    S_WORK  = 4'd5,
    S_CRC5  = 4'd6,
    S_CRC16 = 4'd7,
    S_DONE  = 4'd8
  } rx_state_t;

  // Advance a CRC16 register by one byte, MSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ CRC16_POLY;
    end
    return c;
  endfunction

  // Advance a CRC5 register by one byte, MSB first.
  function automatic logic [4:0] crc5_byte(input logic [4:0] c_in, input logic [7:0] d);
    logic [4:0] c;
    logic       fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[4] ^ d[i];
      c  = {c[3:0], 1'b0};
      if (fb) c = c ^ CRC5_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/com_rx_if.sv
// Receiver-side bundle of the com link: start/done handshake, link byte,
// RAM write port and packet status.
//
// Handshake: the controller raises fs to arm the receiver and holds it for the
// whole packet; the receiver raises fd when the status outputs are final and
// keeps it high until fs is seen low. Dropping fs before fd abandons the packet.
// com_rxd carries one byte per clock with no valid qualifier (8'h00 when idle);
// ram_txen qualifies ram_txa/ram_txd for exactly one cycle per byte.
interface com_rx_if;
  logic        fs;
  logic        fd;
  logic [7:0]  com_rxd;
  logic [11:0] ram_addr_init;
  logic [11:0] ram_txa;
  logic [7:0]  ram_txd;
  logic        ram_txen;
  logic [3:0]  rx_btype;
  logic [11:0] rx_dlen;
  logic [1:0]  rx_err;

  modport master (
    output fs, com_rxd, ram_addr_init,
    input  fd, ram_txa, ram_txd, ram_txen, rx_btype, rx_dlen, rx_err
  );

  modport slave (
    input  fs, com_rxd, ram_addr_init,
    output fd, ram_txa, ram_txd, ram_txen, rx_btype, rx_dlen, rx_err
  );
endinterface

// File: rtl/com_rx_crc.sv
// Payload CRC engine: CRC5 and CRC16 updated in parallel, one byte per
// enabled clock, with a synchronous clear that wins over the enable.
module com_rx_crc
  import com_rx_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_din,
  output logic [7:0]  o_c5,
  output logic [15:0] o_c16
);

  logic [4:0]  r_c5;
  logic [15:0] r_c16;

  // Clear to zero, otherwise fold in one byte when enabled.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_c5  <= '0;
      r_c16 <= '0;
    end else if (i_en) begin
      r_c5  <= crc5_byte(r_c5, i_din);
      r_c16 <= crc16_byte(r_c16, i_din);
    end
  end

  assign o_c5  = {3'b000, r_c5};
  assign o_c16 = r_c16;

endmodule

// File: rtl/com_rx.sv
// com link packet receiver: hunts preamble/SYNC, decodes PID, length,
// payload and CRC, writes payload to packet RAM and reports status via fs/fd.
module com_rx #(
  parameter int          PLEN          = com_rx_pkg::PLEN,
  parameter logic [11:0] RAM_ADDR_INIT = com_rx_pkg::RAM_ADDR_INIT_DEF,
  parameter logic [11:0] MAX_DLEN      = com_rx_pkg::MAX_DLEN_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  com_rx_if.slave               bus,
  output com_rx_pkg::rx_state_t o_dbg_state
);
  import com_rx_pkg::*;

  localparam logic [11:0] PLEN_W    = 12'(PLEN);
  localparam logic [11:0] NLEN_LAST = 12'(NLEN - 1);
  localparam logic [11:0] CLEN_LAST = 12'(CLEN - 1);

  rx_state_t   r_state;
  logic [7:0]  r_rxd;
  logic [11:0] r_num;
  logic [11:0] r_ram_txa;
  logic [7:0]  r_ram_txd;
  logic        r_ram_txen;
  logic [3:0]  r_btype;
  logic [11:0] r_dlen;
  logic [1:0]  r_err;
  logic [7:0]  r_crc_hi;

  rx_state_t   w_state_nx;
  logic [11:0] w_num_nx;
  logic [11:0] w_txa_nx;
  logic [7:0]  w_txd_nx;
  logic        w_txen_nx;
  logic [3:0]  w_btype_nx;
  logic [11:0] w_dlen_nx;
  logic [1:0]  w_err_nx;
  logic [7:0]  w_crc_hi_nx;
  logic        w_crc_clr;
  logic        w_crc_en;
  logic [11:0] w_len;
  logic [7:0]  w_c5;
  logic [15:0] w_c16;

  // Full length as seen while the second length byte sits in r_rxd.
  assign w_len = {r_dlen[11:8], r_rxd};

  com_rx_crc u_crc (
    .i_clk (i_clk),
    .i_clr (i_rst | w_crc_clr),
    .i_en  (w_crc_en),
    .i_din (r_rxd),
    .o_c5  (w_c5),
    .o_c16 (w_c16)
  );

  // Next-state and datapath decisions, all decoding from the registered byte.
  always_comb begin
    w_state_nx  = r_state;
    w_num_nx    = r_num;
    w_txa_nx    = r_ram_txen ? (r_ram_txa + 12'd1) : r_ram_txa;
    w_txd_nx    = r_ram_txd;
    w_txen_nx   = 1'b0;
    w_btype_nx  = r_btype;
    w_dlen_nx   = r_dlen;
    w_err_nx    = r_err;
    w_crc_hi_nx = r_crc_hi;
    w_crc_clr   = 1'b0;
    w_crc_en    = 1'b0;

    case (r_state)
      S_IDLE: w_state_nx = S_WAIT;

      S_WAIT: begin
        // A write still pending from an abandoned packet uses the old address
        // this cycle; the reload only affects the next packet.
        w_num_nx  = '0;
        w_txa_nx  = bus.ram_addr_init;
        w_err_nx  = ERR_OK;
        w_crc_clr = 1'b1;
        if (bus.fs) w_state_nx = S_PREM;
      end

      S_PREM: begin
        if (!bus.fs) begin
          w_state_nx = S_WAIT;
        end else if (r_rxd == PID_PREM) begin
          // Saturate so an arbitrarily long preamble never wraps to zero.
          if (r_num != 12'hFFF) w_num_nx = r_num + 12'd1;
        end else if (r_rxd == PID_SYNC && r_num >= PLEN_W) begin
          w_num_nx   = '0;
          w_state_nx = S_WPID;
        end else begin
          w_num_nx = '0;
        end
      end

      S_WPID: begin
        if (!bus.fs) begin
          w_state_nx = S_WAIT;
        end else begin
          w_dlen_nx = '0;
          w_num_nx  = '0;
          case (r_rxd)
            PID_ACK:   begin w_btype_nx = BAG_ACK;   w_state_nx = S_DONE; end
            PID_NAK:   begin w_btype_nx = BAG_NAK;   w_state_nx = S_DONE; end
            PID_STL:   begin w_btype_nx = BAG_STL;   w_state_nx = S_DONE; end
            PID_STAT:  begin w_btype_nx = BAG_STAT;  w_state_nx = S_DNUM; end
            PID_DATA0: begin w_btype_nx = BAG_DATA0; w_state_nx = S_DNUM; end
            PID_DATA1: begin w_btype_nx = BAG_DATA1; w_state_nx = S_DNUM; end
            default: begin
              w_btype_nx = BAG_NONE;
              w_err_nx   = ERR_PID;
              w_state_nx = S_DONE;
            end
          endcase
        end
      end

      S_DNUM: begin
        if (!bus.fs) begin
          w_state_nx = S_WAIT;
        end else if (r_num != NLEN_LAST) begin
          // Upper nibble of the first length byte is reserved.
          w_dlen_nx = {r_rxd[3:0], 8'h00};
          w_num_nx  = r_num + 12'd1;
        end else begin
          w_dlen_nx = w_len;
          w_num_nx  = '0;
          if (w_len == 12'd0 || {1'b0, w_len} > {1'b0, MAX_DLEN}) begin
            w_err_nx   = ERR_LEN;
            w_state_nx = S_DONE;
          end else begin
            w_state_nx = S_WORK;
          end
        end
      end

      S_WORK: begin
        if (!bus.fs) begin
          w_state_nx = S_WAIT;
        end else begin
          w_txd_nx  = r_rxd;
          w_txen_nx = 1'b1;
          w_crc_en  = 1'b1;
          if (r_num == r_dlen - 12'd1) begin
            w_num_nx   = '0;
            w_state_nx = (r_btype == BAG_STAT) ? S_CRC5 : S_CRC16;
          end else begin
            w_num_nx = r_num + 12'd1;
          end
        end
      end

      S_CRC5: begin
        if (!bus.fs) begin
          w_state_nx = S_WAIT;
        end else begin
          if (r_rxd != w_c5) w_err_nx = ERR_CRC;
          w_state_nx = S_DONE;
        end
      end

      S_CRC16: begin
        if (!bus.fs) begin
          w_state_nx = S_WAIT;
        end else if (r_num != CLEN_LAST) begin
          w_crc_hi_nx = r_rxd;
          w_num_nx    = r_num + 12'd1;
        end else begin
          if ({r_crc_hi, r_rxd} != w_c16) w_err_nx = ERR_CRC;
          w_num_nx   = '0;
          w_state_nx = S_DONE;
        end
      end

      S_DONE: begin
        if (!bus.fs) w_state_nx = S_WAIT;
      end

      default: w_state_nx = S_IDLE;
    endcase
  end

  // State, input byte and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_rxd      <= PID_IDLE;
      r_num      <= '0;
      r_ram_txa  <= RAM_ADDR_INIT;
      r_ram_txd  <= '0;
      r_ram_txen <= 1'b0;
      r_btype    <= BAG_NONE;
      r_dlen     <= '0;
      r_err      <= ERR_OK;
      r_crc_hi   <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_rxd      <= bus.com_rxd;
      r_num      <= w_num_nx;
      r_ram_txa  <= w_txa_nx;
      r_ram_txd  <= w_txd_nx;
      r_ram_txen <= w_txen_nx;
      r_btype    <= w_btype_nx;
      r_dlen     <= w_dlen_nx;
      r_err      <= w_err_nx;
      r_crc_hi   <= w_crc_hi_nx;
    end
  end

  assign bus.fd       = (r_state == S_DONE);
  assign bus.ram_txa  = r_ram_txa;
  assign bus.ram_txd  = r_ram_txd;
  assign bus.ram_txen = r_ram_txen;
  assign bus.rx_btype = r_btype;
  assign bus.rx_dlen  = r_dlen;
  assign bus.rx_err   = r_err;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_com_rx.sv
// Self-checking bench for com_rx: directed packets from the feature list plus
// randomized packets, checked against a frame-level model of the link.
module tb_com_rx;

  logic clk = 1'b0;
  logic rst;
  com_rx_pkg::rx_state_t dbg_state;

  com_rx_if bus();

  com_rx dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // scoreboard: {addr, data} of RAM writes
  logic [19:0] exp_q[$];
  logic [19:0] act_q[$];
  logic [7:0]  pkt_q[$];
  logic [7:0]  fix_q[$];

  int          exp_kind;
  logic [3:0]  exp_btype;
  logic [11:0] exp_dlen;
  logic [1:0]  exp_err;

  // Capture every RAM write the receiver makes.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.ram_txen === 1'b1)
      act_q.push_back({bus.ram_txa, bus.ram_txd});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CRC as the remainder of (message * x^w) divided by the generator polynomial.
  function automatic logic [15:0] ref_crc(input logic [7:0] data[$], input int w, input int poly);
    int unsigned r;
    int unsigned full;
    r = 0;
    full = (32'd1 << w) | poly;
    foreach (data[k]) begin
      for (int b = 7; b >= 0; b--) begin
        r = (r << 1) | 32'(data[k][b]);
        if (((r >> w) & 1) != 0) r = r ^ full;
      end
    end
    for (int z = 0; z < w; z++) begin
      r = r << 1;
      if (((r >> w) & 1) != 0) r = r ^ full;
    end
    return r[15:0];
  endfunction

  // kind: 0 ACK, 1 NAK, 2 STL, 3 STAT, 4 DATA0, 5 DATA1, 6 bad PID
  task automatic build_pkt(input int kind, input int len, input bit bad_crc,
                           input logic [11:0] init, input int npre);
    logic [7:0]  pid;
    logic [7:0]  pay[$];
    logic [7:0]  b;
    logic [11:0] l;
    logic [15:0] c;
    pkt_q.delete();
    exp_q.delete();
    act_q.delete();
    exp_kind  = kind;
    exp_err   = 2'b00;
    exp_dlen  = 12'(len);
    exp_btype = 4'b0000;
    l = 12'(len);
    case (kind)
      0: begin pid = 8'h2D; exp_btype = 4'b0001; end
      1: begin pid = 8'hA5; exp_btype = 4'b0010; end
      2: begin pid = 8'hE1; exp_btype = 4'b0011; end
      3: begin pid = 8'hD2; exp_btype = 4'b1000; end
      4: begin pid = 8'h96; exp_btype = 4'b1101; end
      5: begin pid = 8'h5A; exp_btype = 4'b1110; end
      default: begin
        do pid = 8'($urandom_range(0, 255));
        while (pid == 8'h2D || pid == 8'hA5 || pid == 8'hE1 ||
               pid == 8'hD2 || pid == 8'h96 || pid == 8'h5A);
        exp_err = 2'b10;
      end
    endcase
    for (int i = 0; i < npre; i++) pkt_q.push_back(8'h5A);
    pkt_q.push_back(8'h0F);
    pkt_q.push_back(pid);
    if (kind >= 3 && kind <= 5) begin
      pkt_q.push_back({4'($urandom_range(0, 15)), l[11:8]});
      pkt_q.push_back(l[7:0]);
      if (len == 0) begin
        exp_err = 2'b11;
      end else begin
        for (int i = 0; i < len; i++) begin
          b = (fix_q.size() > i) ? fix_q[i] : 8'($urandom_range(0, 255));
          pay.push_back(b);
          pkt_q.push_back(b);
          exp_q.push_back({init + 12'(i), b});
        end
        if (kind == 3) begin
          c = ref_crc(pay, 5, 32'h05);
          b = c[7:0];
          if (bad_crc) b = b ^ 8'($urandom_range(1, 255));
          pkt_q.push_back(b);
        end else begin
          c = ref_crc(pay, 16, 32'h8005);
          if (bad_crc) c = c ^ 16'($urandom_range(1, 65535));
          pkt_q.push_back(c[15:8]);
          pkt_q.push_back(c[7:0]);
        end
        exp_err = bad_crc ? 2'b01 : 2'b00;
      end
    end
  endtask

  // driver tasks
  task automatic drive_byte(input logic [7:0] b);
    bus.com_rxd = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input int n);
    for (int i = 0; i < n && i < pkt_q.size(); i++) drive_byte(pkt_q[i]);
    bus.com_rxd = 8'h00;
  endtask

  // Called right after the last byte was driven: fd must rise exactly 2 clk later.
  task automatic check_result(input string name);
    check({name, "_fd_early"}, 32'(bus.fd), 32'd0);
    @(posedge clk);
    #1;
    check({name, "_fd_latency"}, 32'(bus.fd), 32'd1);
    check({name, "_err"}, 32'(bus.rx_err), 32'(exp_err));
    if (exp_kind != 6) check({name, "_btype"}, 32'(bus.rx_btype), 32'(exp_btype));
    if (exp_kind >= 3 && exp_kind <= 5) check({name, "_dlen"}, 32'(bus.rx_dlen), 32'(exp_dlen));
    check({name, "_nwrites"}, 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check({name, "_write"}, 32'(act_q[i]), 32'(exp_q[i]));
  endtask

  task automatic release_fs(input string name);
    bus.fs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({name, "_fd_release"}, 32'(bus.fd), 32'd0);
    check({name, "_err_clear"}, 32'(bus.rx_err), 32'd0);
    if (exp_kind != 6) check({name, "_btype_hold"}, 32'(bus.rx_btype), 32'(exp_btype));
  endtask

  task automatic run_pkt(input string name, input int kind, input int len, input bit bad_crc,
                         input logic [11:0] init, input int npre);
    build_pkt(kind, len, bad_crc, init, npre);
    bus.ram_addr_init = init;
    bus.fs = 1'b1;
    send_bytes(pkt_q.size());
    check_result(name);
    release_fs(name);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_fd"}, 32'(bus.fd), 32'd0);
    check({name, "_txen"}, 32'(bus.ram_txen), 32'd0);
    check({name, "_txd"}, 32'(bus.ram_txd), 32'd0);
    check({name, "_err"}, 32'(bus.rx_err), 32'd0);
    check({name, "_btype"}, 32'(bus.rx_btype), 32'd0);
    check({name, "_dlen"}, 32'(bus.rx_dlen), 32'd0);
    check({name, "_txa"}, 32'(bus.ram_txa), 32'h0FF0);
  endtask

  initial begin
    rst = 1'b1;
    bus.fs = 1'b0;
    bus.com_rxd = 8'h00;
    bus.ram_addr_init = 12'h123;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("wait_loads_init", 32'(bus.ram_txa), 32'h0123);

    // handshake packets
    run_pkt("ack", 0, 0, 1'b0, 12'h000, 4);
    run_pkt("nak", 1, 0, 1'b0, 12'h000, 5);
    run_pkt("stl", 2, 0, 1'b0, 12'h000, 4);

    // DATA0 11 22 33 at 100
    fix_q = '{8'h11, 8'h22, 8'h33};
    run_pkt("data0", 4, 3, 1'b0, 12'h100, 4);
    fix_q.delete();

    // STAT with corrupted CRC5
    run_pkt("stat_badcrc", 3, 4, 1'b1, 12'h040, 4);
    run_pkt("stat_ok", 3, 2, 1'b0, 12'h050, 4);

    // short preamble: SYNC ignored
    bus.fs = 1'b1;
    drive_byte(8'h5A); drive_byte(8'h5A); drive_byte(8'h5A);
    drive_byte(8'h0F); drive_byte(8'h2D);
    for (int i = 0; i < 4; i++) begin
      drive_byte(8'h00);
      check("short_prem_fd", 32'(bus.fd), 32'd0);
    end
    bus.fs = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // long preamble, bad PID; DATA1 with length 0
    bus.fs = 1'b1;
    pkt_q = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h0F, 8'h77};
    exp_kind = 6; exp_err = 2'b10; exp_q.delete(); act_q.delete();
    send_bytes(pkt_q.size());
    check_result("bad_pid");
    release_fs("bad_pid");
    run_pkt("len_zero", 5, 0, 1'b0, 12'h000, 4);

    // address wrap
    run_pkt("wrap", 5, 4, 1'b0, 12'hFFE, 4);

    // reset in the middle of the payload, then a clean packet
    build_pkt(4, 5, 1'b0, 12'h300, 4);
    bus.ram_addr_init = 12'h300;
    bus.fs = 1'b1;
    send_bytes(10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("mid_reset");
    bus.fs = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_pkt("after_reset", 4, 5, 1'b0, 12'h300, 4);

    // fs dropped mid-payload: no fd, first two bytes stay written
    build_pkt(5, 6, 1'b0, 12'h200, 5);
    bus.ram_addr_init = 12'h200;
    bus.fs = 1'b1;
    send_bytes(12);
    bus.fs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("abandon_fd", 32'(bus.fd), 32'd0);
    end
    check("abandon_nwrites", 32'(act_q.size()), 32'd2);
    for (int i = 0; i < 2 && i < act_q.size(); i++)
      check("abandon_write", 32'(act_q[i]), 32'(exp_q[i]));

    // randomized packets of every type
    for (int n = 0; n < 16; n++) begin
      int kind;
      int len;
      kind = $urandom_range(0, 6);
      len  = (kind >= 3 && kind <= 5) ? $urandom_range(0, 6) : 0;
      run_pkt("rand", kind, len, ($urandom_range(0, 3) == 0),
              12'($urandom_range(0, 4095)), $urandom_range(4, 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
